spilling_scan_n: RTL

//  Parametrised scan/frame controller for NCH ultrasonic channels: periodically fires one

---
 rtl/spilling_scan_n.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/spilling_scan_n.sv
// Scan/frame controller: fires medir, collects NCH sensor results with timeout,
// discretizes to servo positions and streams an ASCII frame to a 7E1 transmitter.
// Optional checksum character after '#' when SPILLING_CHECKSUM_EN is defined.
//
// state          | meaning
// OCIOSO         | idle, waiting for habilita
// MEDE           | medir pulse, period counter restarts, pronto flags cleared
// AGUARDA        | collecting pronto_sens / medidas until all done or timeout
// ATUALIZA       | discretize latched medidas into posicao
// TRANSMITE      | load tx_dados, pulse tx_partida
// ESPERA_TX      | waiting for tx_pronto
// PROXIMO        | advance character index
// FIM            | fim_ciclo pulse
// ESPERA_PERIODO | waiting for the next measurement period
module spilling_scan_n #(
  parameter int          NCH     = 3,
  parameter int          PERIODO = 1_000_000,
  parameter int          N_PER   = 20,
  parameter int          TIMEOUT = 500_000,
  parameter logic [11:0] L1      = 12'h010,
  parameter logic [11:0] L2      = 12'h020,
  parameter logic [11:0] L3      = 12'h030
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              habilita,
  input  logic [NCH-1:0]    pronto_sens,
  input  logic [12*NCH-1:0] medidas,
  input  logic              tx_pronto,
  output logic              medir,
  output logic              tx_partida,
  output logic [6:0]        tx_dados,
  output logic [2*NCH-1:0]  posicao,
  output logic [NCH-1:0]    timeout,
  output logic              fim_ciclo,
  output logic [3:0]        db_estado
);

`ifdef SPILLING_CHECKSUM_EN
  localparam int NCHAR = 4*NCH + 1;
`else
  localparam int NCHAR = 4*NCH;
`endif
  localparam int CW  = $clog2(4*NCH + 2);
  localparam int CHW = CW - 2;
  localparam logic [N_PER-1:0] PER_LAST  = N_PER'(PERIODO - 1);
  localparam logic [N_PER-1:0] TO_LAST   = N_PER'(TIMEOUT - 1);
  localparam logic [N_PER-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0]    LAST_CHAR = CW'(NCHAR - 1);

  typedef enum logic [3:0] {
    OCIOSO         = 4'd0,
    MEDE           = 4'd1,
    AGUARDA        = 4'd2,
    ATUALIZA       = 4'd3,
    TRANSMITE      = 4'd4,
    ESPERA_TX      = 4'd5,
    PROXIMO        = 4'd6,
    FIM            = 4'd7,
    ESPERA_PERIODO = 4'd8
  } estado_t;

  estado_t          estado;
  logic [N_PER-1:0] cnt;
  logic [NCH-1:0]   flags;
  logic [NCH-1:0]   flags_n;
  logic [11:0]      med_lat [NCH];
  logic [CW-1:0]    char_idx;
  logic [6:0]       char_cur;
  logic [6:0]       cks;
  logic [11:0]      sel_med;
  logic             sel_to;
  logic             sel_last;
  logic [3:0]       digit;

  assign flags_n   = flags | pronto_sens;
  assign db_estado = estado;

  function automatic logic [1:0] discretiza(input logic [11:0] m);
    if (m < L1)      return 2'd0;
    else if (m < L2) return 2'd1;
    else if (m < L3) return 2'd2;
    else             return 2'd3;
  endfunction

  // char_idx[1:0] is the position within a channel group (3 = separator)
  always_comb begin
    sel_med  = '0;
    sel_to   = 1'b0;
    sel_last = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (char_idx[CW-1:2] == CHW'(i)) begin
        sel_med  = med_lat[i];
        sel_to   = timeout[i];
        sel_last = (i == NCH - 1);
      end
    end
    case (char_idx[1:0])
      2'd0:    digit = sel_med[11:8];
      2'd1:    digit = sel_med[7:4];
      2'd2:    digit = sel_med[3:0];
      default: digit = 4'd0;
    endcase
    char_cur = {3'b011, digit};
    if (char_idx[1:0] == 2'd3) char_cur = sel_last ? 7'h23 : 7'h2C;
    else if (sel_to)           char_cur = 7'h3F;
`ifdef SPILLING_CHECKSUM_EN
    if (char_idx == CW'(4*NCH)) char_cur = cks;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= OCIOSO;
      cnt        <= '0;
      flags      <= '0;
      char_idx   <= '0;
      cks        <= '0;
      medir      <= 1'b0;
      tx_partida <= 1'b0;
      tx_dados   <= '0;
      posicao    <= '0;
      timeout    <= '0;
      fim_ciclo  <= 1'b0;
      for (int i = 0; i < NCH; i++) med_lat[i] <= '0;
    end else begin
      medir      <= 1'b0;
      tx_partida <= 1'b0;
      fim_ciclo  <= 1'b0;
      // saturating so a very long frame still reads as an overrun
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      case (estado)
        OCIOSO: begin
          if (habilita) begin
            estado <= MEDE;
            medir  <= 1'b1;
            cnt    <= '0;
          end
        end
        MEDE: begin
          flags  <= '0;
          estado <= AGUARDA;
        end
        AGUARDA: begin
          flags <= flags_n;
          for (int i = 0; i < NCH; i++)
            if (pronto_sens[i]) med_lat[i] <= medidas[12*i +: 12];
          if (&flags_n) begin
            timeout <= '0;
            estado  <= ATUALIZA;
          end else if (cnt == TO_LAST) begin
            timeout <= ~flags_n;
            estado  <= ATUALIZA;
          end
        end
        ATUALIZA: begin
          for (int i = 0; i < NCH; i++)
            if (flags[i]) posicao[2*i +: 2] <= discretiza(med_lat[i]);
          char_idx <= '0;
          cks      <= '0;
          estado   <= TRANSMITE;
        end
        TRANSMITE: begin
          tx_dados   <= char_cur;
          tx_partida <= 1'b1;
          cks        <= cks ^ char_cur;
          estado     <= ESPERA_TX;
        end
        ESPERA_TX: begin
          if (tx_pronto) estado <= PROXIMO;
        end
        PROXIMO: begin
          if (char_idx == LAST_CHAR) begin
            fim_ciclo <= 1'b1;
            estado    <= FIM;
          end else begin
            char_idx <= char_idx + 1'b1;
            estado   <= TRANSMITE;
          end
        end
        FIM: begin
          estado <= habilita ? ESPERA_PERIODO : OCIOSO;
        end
        ESPERA_PERIODO: begin
          if (!habilita) begin
            estado <= OCIOSO;
          end else if (cnt >= PER_LAST) begin
            estado <= MEDE;
            medir  <= 1'b1;
            cnt    <= '0;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule
